// File: rtl/vga_pkg.sv
// Shared video-path definitions.
// Holds the frame-buffer arbiter state encoding and the default sizing
// constants used by the frame-buffer top and its BRAM.
package vga_pkg;

  typedef enum logic {
    ARB_RD_PRIO,
    ARB_WR_FORCE
  } fbuf_arb_state_t;

  localparam int unsigned FBUF_RAM_WIDTH    = 18;
  localparam int unsigned FBUF_RAM_DEPTH    = 1024;
  localparam int unsigned FBUF_STARVE_LIMIT = 8;

endpackage

// File: rtl/fbuf_bram_arbiter.sv
// Frame-buffer BRAM port arbiter.
// Shares one single-port BRAM (1-cycle registered read) between the display
// pixel fetcher (reads, priority) and a pixel writer. Writes are staged in a
// one-entry buffer; reads hitting the buffered address are forwarded from
// it. A starvation counter forces a write slot after STARVE_LIMIT
// consecutive cycles in which a buffered write lost to a read.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   rd_req_i/rd_addr_i   display read request and address
//   rd_gnt_o             read accepted this cycle (combinational)
//   rd_valid_o/rd_data_o read data, one cycle after the grant
//   wr_req_i/wr_addr_i/wr_data_i  write request
//   wr_gnt_o             write buffer can accept (registered)
//   starve_evt_o         marks a forced-write cycle
//   ram_en_o/ram_we_o/ram_addr_o/ram_din_o/ram_dout_i  BRAM port A
module fbuf_bram_arbiter
  import vga_pkg::*;
#(
  parameter  int unsigned RAM_WIDTH    = FBUF_RAM_WIDTH,
  parameter  int unsigned RAM_DEPTH    = FBUF_RAM_DEPTH,
  parameter  int unsigned STARVE_LIMIT = FBUF_STARVE_LIMIT,
  localparam int unsigned ADDR_WIDTH   = $clog2(RAM_DEPTH-1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_valid_o,
  output logic [RAM_WIDTH-1:0]  rd_data_o,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [RAM_WIDTH-1:0]  wr_data_i,
  output logic                  wr_gnt_o,
  output logic                  starve_evt_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [RAM_WIDTH-1:0]  ram_din_o,
  input  logic [RAM_WIDTH-1:0]  ram_dout_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  fbuf_arb_state_t        state_q,      state_d;
  logic                   wbuf_valid_q, wbuf_valid_d;
  logic [ADDR_WIDTH-1:0]  wbuf_addr_q,  wbuf_addr_d;
  logic [RAM_WIDTH-1:0]   wbuf_data_q,  wbuf_data_d;
  logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                   rd_valid_q,   rd_valid_d;
  logic                   wr_gnt_q,     wr_gnt_d;
  logic                   byp_hit_q,    byp_hit_d;
  logic [RAM_WIDTH-1:0]   byp_data_q,   byp_data_d;
  // Last driven BRAM address/data, replayed on idle cycles to avoid toggling.
  logic [ADDR_WIDTH-1:0]  addr_hold_q,  addr_hold_d;
  logic [RAM_WIDTH-1:0]   din_hold_q,   din_hold_d;

  logic                   rd_gnt;
  logic                   wr_issue;
  logic                   starve_evt;
  logic                   ram_en;
  logic                   ram_we;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic [RAM_WIDTH-1:0]   ram_din;

  always_comb begin
    state_d      = state_q;
    wbuf_valid_d = wbuf_valid_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_data_d  = wbuf_data_q;
    starve_cnt_d = starve_cnt_q;
    byp_hit_d    = byp_hit_q;
    byp_data_d   = byp_data_q;
    rd_gnt       = 1'b0;
    wr_issue     = 1'b0;
    starve_evt   = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = addr_hold_q;
    ram_din      = din_hold_q;

    // The forced slot lasts one cycle whether or not a write was pending.
    if (state_q == ARB_WR_FORCE) begin
      state_d = ARB_RD_PRIO;
    end

    if (state_q == ARB_WR_FORCE && wbuf_valid_q) begin
      wr_issue   = 1'b1;
      starve_evt = 1'b1;
    end else if (rd_req_i) begin
      rd_gnt   = 1'b1;
      ram_en   = 1'b1;
      ram_addr = rd_addr_i;
    end else if (wbuf_valid_q) begin
      wr_issue = 1'b1;
    end

    if (wr_issue) begin
      ram_en       = 1'b1;
      ram_we       = 1'b1;
      ram_addr     = wbuf_addr_q;
      ram_din      = wbuf_data_q;
      wbuf_valid_d = 1'b0;
      starve_cnt_d = '0;
    end

    if (rd_gnt && wbuf_valid_q) begin
      if (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
        state_d = ARB_WR_FORCE;
      end
      if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end

    // Forwarding looks at the buffer before this cycle's accepted write, so a
    // same-cycle write to the read address is ordered after the read.
    if (rd_gnt) begin
      byp_hit_d  = wbuf_valid_q && (wbuf_addr_q == rd_addr_i);
      byp_data_d = wbuf_data_q;
    end

    // A grant implies the buffer was empty, so acceptance never coincides
    // with a write issue.
    if (wr_req_i && wr_gnt_q) begin
      wbuf_valid_d = 1'b1;
      wbuf_addr_d  = wr_addr_i;
      wbuf_data_d  = wr_data_i;
    end

    wr_gnt_d    = !wbuf_valid_d;
    rd_valid_d  = rd_gnt;
    addr_hold_d = ram_addr;
    din_hold_d  = ram_din;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ARB_RD_PRIO;
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      starve_cnt_q <= '0;
      rd_valid_q   <= 1'b0;
      wr_gnt_q     <= 1'b0;
      byp_hit_q    <= 1'b0;
      byp_data_q   <= '0;
      addr_hold_q  <= '0;
      din_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      starve_cnt_q <= starve_cnt_d;
      rd_valid_q   <= rd_valid_d;
      wr_gnt_q     <= wr_gnt_d;
      byp_hit_q    <= byp_hit_d;
      byp_data_q   <= byp_data_d;
      addr_hold_q  <= addr_hold_d;
      din_hold_q   <= din_hold_d;
    end
  end

  assign rd_gnt_o     = rd_gnt;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = byp_hit_q ? byp_data_q : ram_dout_i;
  assign wr_gnt_o     = wr_gnt_q;
  assign starve_evt_o = starve_evt;
  assign ram_en_o     = ram_en;
  assign ram_we_o     = ram_we;
  assign ram_addr_o   = ram_addr;
  assign ram_din_o    = ram_din;

  // The forced slot is only ever entered with a write pending.
  force_has_write_a : assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    (state_q == ARB_WR_FORCE) |-> wbuf_valid_q
  );

endmodule

// File: tb/tb_fbuf_bram_arbiter.sv
module tb_fbuf_bram_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 18;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt_o, rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt_o, starve_evt_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_din_o, ram_dout;

  fbuf_bram_arbiter #(
    .RAM_WIDTH   (18),
    .RAM_DEPTH   (1024),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .rd_gnt_o    (rd_gnt_o),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .wr_req_i    (wr_req),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_gnt_o    (wr_gnt_o),
    .starve_evt_o(starve_evt_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_din_o   (ram_din_o),
    .ram_dout_i  (ram_dout)
  );

  always #5 clk = ~clk;

  // Read-first single-port BRAM with registered output.
  logic [DW-1:0] bram [0:1023];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) bram[ram_addr_o] <= ram_din_o;
      ram_dout <= bram[ram_addr_o];
    end
  end

  // Logical memory: newest value accepted by the arbiter for each address.
  logic [DW-1:0] lmem [0:1023];
  initial begin
    ram_dout = '0;
    for (int i = 0; i < 1024; i++) begin
      bram[i] = DW'(i * 613 + 5);
      lmem[i] = DW'(i * 613 + 5);
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected read data queued on grant, checked on the next cycle.
  logic [DW-1:0] exp_q [$];
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0) begin
        chk("sb_rd_valid", 32'(rd_valid_o), 32'd1);
        chk("sb_rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
      end else if (rd_valid_o) begin
        chk("sb_spurious_rd_valid", 32'(rd_valid_o), 32'd0);
      end
      if (rd_req && rd_gnt_o) exp_q.push_back(lmem[rd_addr]);
      if (wr_req && wr_gnt_o) lmem[wr_addr] = wr_data;
    end
  end

  typedef struct {
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          e_rd_gnt;
    logic          e_wr_gnt;
    logic          e_en;
    logic          e_we;
    logic          e_starve;
    logic          e_rd_valid;
    logic [AW-1:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic rq, input logic [AW-1:0] ra,
                              input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic g, input logic wg, input logic en, input logic we,
                              input logic st, input logic rv, input logic [AW-1:0] ea);
    vec_t v;
    v.rd_req = rq; v.rd_addr = ra; v.wr_req = wq; v.wr_addr = wa; v.wr_data = wd;
    v.e_rd_gnt = g; v.e_wr_gnt = wg; v.e_en = en; v.e_we = we;
    v.e_starve = st; v.e_rd_valid = rv; v.e_addr = ea;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    string s;
    rd_req = v.rd_req; rd_addr = v.rd_addr;
    wr_req = v.wr_req; wr_addr = v.wr_addr; wr_data = v.wr_data;
    @(negedge clk);
    s = $sformatf("[%0d]", idx);
    chk({"rd_gnt", s},   32'(rd_gnt_o),     32'(v.e_rd_gnt));
    chk({"wr_gnt", s},   32'(wr_gnt_o),     32'(v.e_wr_gnt));
    chk({"ram_en", s},   32'(ram_en_o),     32'(v.e_en));
    chk({"ram_we", s},   32'(ram_we_o),     32'(v.e_we));
    chk({"starve", s},   32'(starve_evt_o), 32'(v.e_starve));
    chk({"rd_valid", s}, 32'(rd_valid_o),   32'(v.e_rd_valid));
    if (v.e_en) chk({"ram_addr", s}, 32'(ram_addr_o), 32'(v.e_addr));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  vec_t tbl [$];
  logic [DW-1:0] saved;
  logic got;
  int cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    idle();
    #1;
    chk("reset_wr_gnt", 32'(wr_gnt_o), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("reset_ram_en", 32'(ram_en_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Single write then readback.
    tbl.push_back(mk(0, 10'h000, 0, 10'h000, 18'h00000, 0, 0, 0, 0, 0, 0, 10'h000));
    tbl.push_back(mk(0, 10'h000, 1, 10'h010, 18'h2A5A5, 0, 1, 0, 0, 0, 0, 10'h000));
    tbl.push_back(mk(0, 10'h000, 0, 10'h000, 18'h00000, 0, 0, 1, 1, 0, 0, 10'h010));
    tbl.push_back(mk(0, 10'h000, 0, 10'h000, 18'h00000, 0, 1, 0, 0, 0, 0, 10'h000));
    tbl.push_back(mk(1, 10'h010, 0, 10'h000, 18'h00000, 1, 1, 1, 0, 0, 0, 10'h010));
    tbl.push_back(mk(0, 10'h000, 0, 10'h000, 18'h00000, 0, 1, 0, 0, 0, 1, 10'h000));
    // Forwarding under continuous reads, leading to a forced write slot.
    tbl.push_back(mk(1, 10'h3FF, 1, 10'h3FF, 18'h00123, 1, 1, 1, 0, 0, 0, 10'h3FF));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 10'h3FF, 0, 10'h000, 18'h00000, 1, 0, 1, 0, 0, 1, 10'h3FF));
    tbl.push_back(mk(1, 10'h3FF, 0, 10'h000, 18'h00000, 0, 0, 1, 1, 1, 1, 10'h3FF));
    tbl.push_back(mk(1, 10'h3FF, 0, 10'h000, 18'h00000, 1, 1, 1, 0, 0, 0, 10'h3FF));
    tbl.push_back(mk(0, 10'h000, 0, 10'h000, 18'h00000, 0, 1, 0, 0, 0, 1, 10'h000));

    foreach (tbl[i]) apply(tbl[i], i);
    idle();
    chk("bram_3ff_after_drain", 32'(bram[10'h3FF]), 32'h00123);

    // Idle port: no enables, address held at last driven value.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_ram_en", 32'(ram_en_o), 32'd0);
      chk("idle_addr_hold", 32'(ram_addr_o), 32'h3FF);
      @(posedge clk); #1;
    end

    // Back-to-back writes 0x000..0x00F.
    cyc = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      wr_req = 1'b1; wr_addr = AW'(i); wr_data = DW'(18'h15000 + i * 37);
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge clk);
        got = wr_gnt_o;
        @(posedge clk); #1;
        cyc++;
      end
      chk("b2b_wr_gnt", 32'(got), 32'd1);
    end
    idle();
    @(negedge clk);
    chk("b2b_last_we", 32'(ram_we_o), 32'd1);
    @(posedge clk); #1;
    cyc++;
    chk("b2b_cycles", 32'(cyc), 32'd32);
    for (int unsigned i = 0; i < 16; i++) begin
      rd_req = 1'b1; rd_addr = AW'(i);
      @(negedge clk);
      chk("b2b_rd_gnt", 32'(rd_gnt_o), 32'd1);
      @(posedge clk); #1;
    end
    idle();
    repeat (2) begin @(posedge clk); #1; end

    // Reset with a buffered write pending and a read in flight.
    saved = lmem[10'h055];
    wr_req = 1'b1; wr_addr = 10'h055; wr_data = 18'h3C3C3;
    @(negedge clk);
    chk("rst_seq_wr_gnt", 32'(wr_gnt_o), 32'd1);
    @(posedge clk); #1;
    idle();
    rd_req = 1'b1; rd_addr = 10'h100;
    @(negedge clk);
    chk("rst_seq_rd_gnt", 32'(rd_gnt_o), 32'd1);
    chk("rst_seq_we", 32'(ram_we_o), 32'd0);
    #2;
    rstn = 1'b0;
    rd_req = 1'b0;
    #1;
    chk("rst_async_wr_gnt", 32'(wr_gnt_o), 32'd0);
    chk("rst_async_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_async_ram_en", 32'(ram_en_o), 32'd0);
    lmem[10'h055] = saved;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rd_valid", 32'(rd_valid_o), 32'd0);
      chk("post_rst_ram_en", 32'(ram_en_o), 32'd0);
      @(posedge clk); #1;
    end
    chk("post_rst_bram_055", 32'(bram[10'h055]), 32'(saved));
    rd_req = 1'b1; rd_addr = 10'h055;
    @(posedge clk); #1;
    idle();
    repeat (2) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
